// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised simple-dual-port RAM.
// Holds the clear-sequencer state encoding and read-during-write policy codes.
package ram_pkg;

    typedef enum logic {
        S_CLR,
        S_RUN
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps zeros through every word after reset or on request.
// While sweeping, BUSY is high and the array port belongs to the sequencer.
module ram_clr_seq
    import ram_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [CW-1:0] clr_ad
);

    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    // State and sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: advance the sweep, or start a new one on a clear request.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_CLR: begin
                if (cnt == LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (clr) begin
                    state_nx = S_CLR;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_CLR;
                cnt_nx   = '0;
            end
        endcase
    end

    assign busy   = (state == S_CLR);
    assign clr_we = busy;
    assign clr_ad = cnt;

endmodule

// File: rtl/ram_sdp_param.sv
// Simple-dual-port RAM with bit-masked writes and selectable RDW policy.
// The clear sequencer owns the write port while BUSY; reads are then dropped.
module ram_sdp_param
    import ram_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int DEPTH    = 256,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_AD,
    input  logic [DW-1:0] WR_DT,
    input  logic [DW-1:0] WR_MSK,
    input  logic          RD_EN,
    input  logic [AW-1:0] RD_AD,
    output logic [DW-1:0] RD_DT,
    output logic          RD_VLD,
    output logic          BUSY
);

    localparam int          CW    = $clog2(DEPTH);
    localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic          busy;
    logic          clr_we;
    logic [CW-1:0] clr_ad;

    ram_clr_seq #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_seq (
        .clk    (CLK),
        .rst    (RST),
        .clr    (CLR),
        .busy   (busy),
        .clr_we (clr_we),
        .clr_ad (clr_ad)
    );

    logic          wr_ok;
    logic          wr_fire;
    logic          rd_ok;
    logic          rd_fire;
    logic          mem_we;
    logic [CW-1:0] mem_ad;
    logic [DW-1:0] mem_dt;
    logic [DW-1:0] mem_msk;
    logic [DW-1:0] rd_raw;
    logic [DW-1:0] rd_word;

    assign wr_ok   = ({1'b0, WR_AD} < LIMIT);
    assign rd_ok   = ({1'b0, RD_AD} < LIMIT);
    assign wr_fire = !busy && !CLR && WR_EN && wr_ok;
    assign rd_fire = !busy && !CLR && RD_EN;

    assign mem_we  = clr_we || wr_fire;
    assign mem_ad  = busy ? clr_ad : WR_AD[CW-1:0];
    assign mem_dt  = busy ? '0 : WR_DT;
    assign mem_msk = busy ? '1 : WR_MSK;

    // Array write: the sweep uses a full mask with zero data.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_ad] <= (mem[mem_ad] & ~mem_msk)
                         | (mem_dt & mem_msk);
        end
    end

    assign rd_raw = mem[RD_AD[CW-1:0]];

    // Read word: zero when out of range, merged new data on an RDW hit.
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            if (RDW_MODE == RDW_NEW && wr_fire && WR_AD == RD_AD) begin
                rd_word = (rd_raw & ~WR_MSK) | (WR_DT & WR_MSK);
            end else begin
                rd_word = rd_raw;
            end
        end
    end

    logic [DW-1:0] s1_dt;
    logic          s1_vld;

    // First read stage; data holds until the next accepted read.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_dt  <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= rd_fire;
            if (rd_fire) begin
                s1_dt <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DW-1:0] s2_dt;
            logic          s2_vld;

            // Optional output stage adding one cycle of latency.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s2_dt  <= '0;
                    s2_vld <= 1'b0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dt <= s1_dt;
                    end
                end
            end

            assign RD_DT  = s2_dt;
            assign RD_VLD = s2_vld;
        end else begin : g_noreg
            assign RD_DT  = s1_dt;
            assign RD_VLD = s1_vld;
        end
    endgenerate

    assign BUSY = busy;

endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench for ram_sdp_param across four parameter sets.
// All instances share stimulus; each scenario checks the relevant instance.
module tb_ram_sdp_param;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLR = 1'b0;
    logic       WR_EN = 1'b0;
    logic [7:0] WR_AD = '0;
    logic [7:0] WR_DT = '0;
    logic [7:0] WR_MSK = '0;
    logic       RD_EN = 1'b0;
    logic [7:0] RD_AD = '0;

    logic [7:0] dt0, dt1, dt2, dt3;
    logic       vld0, vld1, vld2, vld3;
    logic       bsy0, bsy1, bsy2, bsy3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    ram_sdp_param u0 (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .WR_EN(WR_EN), .WR_AD(WR_AD), .WR_DT(WR_DT), .WR_MSK(WR_MSK),
        .RD_EN(RD_EN), .RD_AD(RD_AD),
        .RD_DT(dt0), .RD_VLD(vld0), .BUSY(bsy0)
    );

    ram_sdp_param #(.RDW_MODE(1)) u1 (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .WR_EN(WR_EN), .WR_AD(WR_AD), .WR_DT(WR_DT), .WR_MSK(WR_MSK),
        .RD_EN(RD_EN), .RD_AD(RD_AD),
        .RD_DT(dt1), .RD_VLD(vld1), .BUSY(bsy1)
    );

    ram_sdp_param #(.OUT_REG(1)) u2 (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .WR_EN(WR_EN), .WR_AD(WR_AD), .WR_DT(WR_DT), .WR_MSK(WR_MSK),
        .RD_EN(RD_EN), .RD_AD(RD_AD),
        .RD_DT(dt2), .RD_VLD(vld2), .BUSY(bsy2)
    );

    ram_sdp_param #(.DEPTH(200)) u3 (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .WR_EN(WR_EN), .WR_AD(WR_AD), .WR_DT(WR_DT), .WR_MSK(WR_MSK),
        .RD_EN(RD_EN), .RD_AD(RD_AD),
        .RD_DT(dt3), .RD_VLD(vld3), .BUSY(bsy3)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] m);
        WR_EN = 1'b1; WR_AD = a; WR_DT = d; WR_MSK = m;
        cyc();
        WR_EN = 1'b0;
    endtask

    task automatic do_rd(input logic [7:0] a);
        RD_EN = 1'b1; RD_AD = a;
        cyc();
        RD_EN = 1'b0;
    endtask

    task automatic test_reset();
        int n, n3, vbad;
        RST = 1'b1; RD_EN = 1'b1; RD_AD = 8'h00;
        cyc(); cyc();
        total++;
        if (bsy0 !== 1'b1 || dt0 !== 8'h00 || vld0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: busy=%b dt=%h vld=%b want 1 00 0",
                     bsy0, dt0, vld0);
        end
        RST = 1'b0;
        n = 0; n3 = 0; vbad = 0;
        while (bsy0 && n < 400) begin
            cyc();
            n++;
            if (vld0 !== 1'b0) vbad++;
            if (!bsy3 && n3 == 0) n3 = n;
        end
        RD_EN = 1'b0;
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL reset_busy256: got %0d want 256", n);
        end
        total++;
        if (n3 != 200) begin
            bad++;
            $display("FAIL reset_busy200: got %0d want 200", n3);
        end
        total++;
        if (vbad != 0) begin
            bad++;
            $display("FAIL reset_vld_low: got %0d pulses want 0", vbad);
        end
    endtask

    task automatic test_clear_reads();
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            do_rd(addrs[i]);
            total++;
            if (dt0 !== 8'h00 || vld0 !== 1'b1) begin
                bad++;
                $display("FAIL clear_rd_%h: dt=%h vld=%b want 00 1",
                         addrs[i], dt0, vld0);
            end
        end
    endtask

    task automatic test_mask();
        do_wr(8'h10, 8'hFF, 8'hFF);
        do_wr(8'h10, 8'h00, 8'h0F);
        do_rd(8'h10);
        total++;
        if (dt0 !== 8'hF0 || vld0 !== 1'b1) begin
            bad++;
            $display("FAIL mask_rd: dt=%h vld=%b want f0 1", dt0, vld0);
        end
        cyc();
        total++;
        if (dt0 !== 8'hF0 || vld0 !== 1'b0) begin
            bad++;
            $display("FAIL rd_hold: dt=%h vld=%b want f0 0", dt0, vld0);
        end
    endtask

    task automatic test_rdw();
        do_wr(8'h22, 8'h22, 8'hFF);
        WR_EN = 1'b1; WR_AD = 8'h22; WR_DT = 8'h5A; WR_MSK = 8'hFF;
        RD_EN = 1'b1; RD_AD = 8'h22;
        cyc();
        WR_EN = 1'b0; RD_EN = 1'b0;
        total++;
        if (dt0 !== 8'h22) begin
            bad++;
            $display("FAIL rdw_old: got %h want 22", dt0);
        end
        total++;
        if (dt1 !== 8'h5A) begin
            bad++;
            $display("FAIL rdw_new: got %h want 5a", dt1);
        end
        do_rd(8'h22);
        total++;
        if (dt0 !== 8'h5A) begin
            bad++;
            $display("FAIL rdw_after: got %h want 5a", dt0);
        end
    endtask

    task automatic test_latency();
        logic       ev [5];
        logic [7:0] ed [5];
        ev[0] = 0; ev[1] = 1; ev[2] = 1; ev[3] = 1; ev[4] = 0;
        ed[0] = 8'h00; ed[1] = 8'h31; ed[2] = 8'h32;
        ed[3] = 8'h33; ed[4] = 8'h33;
        do_wr(8'h01, 8'h31, 8'hFF);
        do_wr(8'h02, 8'h32, 8'hFF);
        do_wr(8'h03, 8'h33, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            RD_EN = (i < 3);
            RD_AD = 8'(i + 1);
            cyc();
            total++;
            if (vld2 !== ev[i] || (ev[i] && dt2 !== ed[i])) begin
                bad++;
                $display("FAIL lat2_c%0d: vld=%b dt=%h want %b %h",
                         i, vld2, dt2, ev[i], ed[i]);
            end
        end
        RD_EN = 1'b0;
    endtask

    task automatic test_clr();
        int n, n3;
        do_wr(8'hFF, 8'hAB, 8'hFF);
        CLR = 1'b1;
        WR_EN = 1'b1; WR_AD = 8'h00; WR_DT = 8'h11; WR_MSK = 8'hFF;
        cyc();
        CLR = 1'b0; WR_EN = 1'b0;
        total++;
        if (bsy0 !== 1'b1) begin
            bad++;
            $display("FAIL clr_busy_rise: got %b want 1", bsy0);
        end
        n = 0; n3 = 0;
        while (bsy0 && n < 400) begin
            cyc();
            n++;
            if (!bsy3 && n3 == 0) n3 = n;
        end
        total++;
        if (n != 256 || n3 != 200) begin
            bad++;
            $display("FAIL clr_busy_len: got %0d/%0d want 256/200", n, n3);
        end
        do_rd(8'h00);
        total++;
        if (dt0 !== 8'h00) begin
            bad++;
            $display("FAIL clr_rd_00: got %h want 00", dt0);
        end
        do_rd(8'hFF);
        total++;
        if (dt0 !== 8'h00) begin
            bad++;
            $display("FAIL clr_rd_ff: got %h want 00", dt0);
        end
    endtask

    task automatic test_range();
        do_wr(8'hC8, 8'h77, 8'hFF);
        do_rd(8'hC8);
        total++;
        if (dt3 !== 8'h00 || vld3 !== 1'b1) begin
            bad++;
            $display("FAIL oor_rd: dt=%h vld=%b want 00 1", dt3, vld3);
        end
        total++;
        if (dt0 !== 8'h77) begin
            bad++;
            $display("FAIL inrange_c8: got %h want 77", dt0);
        end
        do_wr(8'hC7, 8'h66, 8'hFF);
        do_rd(8'hC7);
        total++;
        if (dt3 !== 8'h66) begin
            bad++;
            $display("FAIL last_word: got %h want 66", dt3);
        end
    endtask

    task automatic test_reset_mid();
        int n, n3;
        RD_EN = 1'b1; RD_AD = 8'h01;
        cyc();
        RD_EN = 1'b0;
        RST = 1'b1;
        #1;
        total++;
        if (vld2 !== 1'b0 || dt2 !== 8'h00 || bsy2 !== 1'b1) begin
            bad++;
            $display("FAIL rst_inflight: vld=%b dt=%h busy=%b want 0 00 1",
                     vld2, dt2, bsy2);
        end
        cyc();
        RST = 1'b0;
        repeat (100) cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        n = 0; n3 = 0;
        while (bsy0 && n < 400) begin
            cyc();
            n++;
            if (!bsy3 && n3 == 0) n3 = n;
        end
        total++;
        if (n3 != 200) begin
            bad++;
            $display("FAIL midclr_200: got %0d want 200", n3);
        end
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL midclr_256: got %0d want 256", n);
        end
    endtask

    initial begin
        test_reset();
        test_clear_reads();
        test_mask();
        test_rdw();
        test_latency();
        test_clr();
        test_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_sdp_param.md
# ram_sdp_param

Parametrised simple-dual-port RAM (one write port, one read port, one clock) that replaces the fixed 8-bit x 256-entry buffer.

- Adds configurable width and depth, a per-bit write mask, and a selectable read-during-write policy.
- Adds optional output registering with a read-valid strobe.
- Memory clear is a hardware sequencer, so reset never touches the array combinationally.
- Used as the generic scratch and buffer RAM by datapath blocks.

## Interface

Parameters:
- DW, 8, data width in bits (1 to 64)
- AW, 8, address width
- DEPTH, 256, number of words; 2 ≤ DEPTH ≤ 2^AW
- OUT_REG, 0, 0: read latency 1; 1: extra output register, read latency 2
- RDW_MODE, 0, same-address read and write in one cycle. 0 returns old data; 1 returns new (masked-merged) data

Ports:
- CLK, in, 1, single clock; all state updates on rising edge
- RST, in, 1, asynchronous, active-high reset
- CLR, in, 1, synchronous request to zero the whole array
- WR_EN, in, 1, write strobe
- WR_AD, in, AW, write address
- WR_DT, in, DW, write data
- WR_MSK, in, DW, per-bit write enable; 1 = bit written
- RD_EN, in, 1, read strobe
- RD_AD, in, AW, read address
- RD_DT, out, DW, read data; held until next valid read
- RD_VLD, out, 1, one-cycle pulse when RD_DT carries new read data
- BUSY, out, 1, clear sequence in progress; port accesses ignored

## Operation

- FSM states: S_CLR, S_RUN.
- RST assertion (asynchronous):
  - State becomes S_CLR, clear counter goes to 0.
  - BUSY=1, RD_DT=0, RD_VLD=0, pipeline valid bits cleared.
  - The array itself is not reset.
- S_CLR:
  - Each cycle writes 0 to mem[counter], then the counter increments.
  - After writing DEPTH-1, next state is S_RUN.
  - WR_EN, RD_EN and CLR are ignored; RD_VLD stays 0.
- S_RUN, CLR=1:
  - Next state is S_CLR, counter goes to 0.
  - A write or read in the same cycle is dropped.
- S_RUN, write: on WR_EN, mem[WR_AD] = (mem[WR_AD] & ~WR_MSK) | (WR_DT & WR_MSK).
- S_RUN, read: on RD_EN, mem[RD_AD] is captured. The RDW_MODE policy applies when RD_AD == WR_AD with WR_EN in the same cycle.
- Address ≥ DEPTH (only possible when DEPTH < 2^AW):
  - Write is dropped.
  - Read returns 0 with RD_VLD asserted normally.
- Reads with RD_EN=0 leave RD_DT unchanged.

## Timing

- Reset values: BUSY=1, RD_DT=0, RD_VLD=0.
- Clear duration:
  - After the RST falling edge, BUSY stays high for exactly DEPTH rising edges. That is 256 cycles at default parameters.
  - The first accepted access is in the cycle BUSY reads 0.
- CLR-initiated clear: BUSY rises the cycle after CLR is sampled and lasts DEPTH cycles.
- Read latency:
  - OUT_REG=0: RD_DT and RD_VLD are valid after the edge that samples RD_EN (1 cycle).
  - OUT_REG=1: valid one edge later (2 cycles).
  - Back-to-back reads every cycle are fully pipelined.
- Write-to-read visibility:
  - A write at edge N is visible to a read sampled at edge N+1.
  - A read sampled at edge N itself follows RDW_MODE.
- Reset mid-operation:
  - An in-flight read is discarded and no RD_VLD pulse appears.
  - A mid-clear RST restarts the sweep at address 0.
- RST has priority over everything; CLR has priority over WR_EN and RD_EN.

## Structure

- Shared package ram_pkg holds:
  - the state enum {S_CLR, S_RUN};
  - constants RDW_OLD=0 and RDW_NEW=1.
- Sub-module ram_clr_seq holds the FSM and the clear counter of width $clog2(DEPTH). It outputs BUSY, the clear write enable and the clear address.
- The top level muxes the clear port onto the write port and holds the array plus the read pipeline.

## Test plan

All scenarios use default parameters unless stated.
- Reset and clear:
  - Pulse RST, hold RD_EN=1.
  - Required: BUSY=1 for 256 cycles and RD_VLD=0 throughout.
  - Then read addresses 0x00, 0x7F and 0xFF: each returns 0x00.
- Masked write:
  - Write 0xFF to 0x10 with mask 0xFF, then 0x00 with mask 0x0F.
  - Required: read of 0x10 returns 0xF0.
- Read-during-write:
  - With 0x22 previously written to 0x22, write 0x5A to 0x22 and read 0x22 in the same cycle.
  - Required: RDW_MODE=0 returns 0x22 (the old value); RDW_MODE=1 returns 0x5A.
- Latency:
  - OUT_REG=1, reads of 0x01, 0x02, 0x03 on consecutive cycles.
  - Required: RD_VLD high for 3 cycles starting 2 cycles after the first RD_EN, with data in order.
- CLR and boundary:
  - Write 0xAB to 0xFF, then assert CLR together with a write of 0x11 to 0x00.
  - Required: the write is dropped, BUSY=1 for 256 cycles, and reads of 0x00 and 0xFF return 0x00.
- Out-of-range and reset mid-clear:
  - DEPTH=200: write 0x77 to 0xC8; reading 0xC8 returns 0x00 with RD_VLD=1.
  - Assert RST at clear cycle 100: BUSY stays high for 200 cycles after release.
